// File: rtl/ex_wb_if.sv
// ID/EX -> EX/WB stage bundle: operands and controls in, registered write-back and Stall out.
interface ex_wb_if;
  logic [1:0] opcodeIn;
  logic [7:0] ReadDataIn;
  logic [7:0] ImmediateDataIn;
  logic [2:0] ReadRegisterIn;
  logic [2:0] WriteRegisterIn;
  logic       WriteSignalIn;
  logic [7:0] ResultOut;
  logic [2:0] WriteRegisterOut;
  logic       WriteSignalOut;
  logic       Stall;

  modport master (
    output opcodeIn, ReadDataIn, ImmediateDataIn, ReadRegisterIn, WriteRegisterIn, WriteSignalIn,
    input  ResultOut, WriteRegisterOut, WriteSignalOut, Stall
  );

  modport slave (
    input  opcodeIn, ReadDataIn, ImmediateDataIn, ReadRegisterIn, WriteRegisterIn, WriteSignalIn,
    output ResultOut, WriteRegisterOut, WriteSignalOut, Stall
  );
endinterface

// File: rtl/ex_wb.sv
// EX/WB stage: single-cycle ADD/MOVI/XOR, multi-cycle SHL (one bit per edge) with upstream Stall.
// Define EX_FORWARD_EN to forward the registered result back into operand A.
module ex_wb (
  input logic   clk,
  input logic   Reset,
  ex_wb_if.slave bus
);
  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpMovi = 2'b01;
  localparam logic [1:0] OpXor  = 2'b10;
  localparam logic [1:0] OpShl  = 2'b11;

  typedef enum logic {StIdle, StShift} state_e;

  state_e     r_state, w_state_next;
  logic [7:0] r_result, r_shift;
  logic [2:0] r_wr_reg, r_count, r_cap_reg;
  logic       r_wr_en, r_cap_en;
  logic [7:0] w_a, w_alu, w_shift_next;
  logic [2:0] w_n;
  logic       w_shl_start, w_stall;

  assign w_n          = bus.ImmediateDataIn[2:0];
  assign w_shift_next = {r_shift[6:0], 1'b0};

`ifdef EX_FORWARD_EN
  assign w_a = (r_wr_en && (r_wr_reg == bus.ReadRegisterIn)) ? r_result : bus.ReadDataIn;
`else
  assign w_a = bus.ReadDataIn;
`endif

  always_comb begin
    w_alu = w_a;
    unique case (bus.opcodeIn)
      OpAdd:   w_alu = w_a + bus.ImmediateDataIn;
      OpMovi:  w_alu = bus.ImmediateDataIn;
      OpXor:   w_alu = w_a ^ bus.ImmediateDataIn;
      OpShl:   w_alu = w_a;  // only reached with N = 0
      default: w_alu = w_a;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_shl_start  = 1'b0;
    w_stall      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.opcodeIn == OpShl && w_n != 3'd0) begin
          w_shl_start  = 1'b1;
          w_stall      = 1'b1;
          w_state_next = StShift;
        end
      end
      StShift: begin
        w_stall = (r_count > 3'd1);
        if (r_count == 3'd1) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= StIdle;
      r_result  <= 8'h00;
      r_wr_reg  <= 3'd0;
      r_wr_en   <= 1'b0;
      r_shift   <= 8'h00;
      r_count   <= 3'd0;
      r_cap_reg <= 3'd0;
      r_cap_en  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (w_shl_start) begin
            r_shift   <= w_a;
            r_count   <= w_n;
            r_cap_reg <= bus.WriteRegisterIn;
            r_cap_en  <= bus.WriteSignalIn;
            r_wr_en   <= 1'b0;
          end else begin
            r_result <= w_alu;
            r_wr_reg <= bus.WriteRegisterIn;
            r_wr_en  <= bus.WriteSignalIn;
          end
        end
        StShift: begin
          r_shift <= w_shift_next;
          r_count <= r_count - 3'd1;
          if (r_count == 3'd1) begin
            r_result <= w_shift_next;
            r_wr_reg <= r_cap_reg;
            r_wr_en  <= r_cap_en;
          end else begin
            r_wr_en <= 1'b0;
          end
        end
        default: r_wr_en <= 1'b0;
      endcase
    end
  end

  assign bus.ResultOut        = r_result;
  assign bus.WriteRegisterOut = r_wr_reg;
  assign bus.WriteSignalOut   = r_wr_en;
  assign bus.Stall            = w_stall & ~Reset;
endmodule

// File: tb/tb_ex_wb.sv
// Bench for ex_wb: directed scenarios then held-while-stalled random traffic, against a
// transaction-level model (SHL result computed as (A << N) mod 256 with an N-edge delay).
module tb_ex_wb;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  ex_wb_if bus ();
  ex_wb dut (.clk(clk), .Reset(Reset), .bus(bus));

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: visible outputs plus one pending SHL.
  logic [7:0] m_res;
  logic [2:0] m_wreg;
  logic       m_wen;
  logic       m_known;
  int         m_rem;
  logic [7:0] m_pres;
  logic [2:0] m_preg;
  logic       m_pen;
  logic       last_stall;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] rd, input logic [7:0] imm,
                       input logic [2:0] rr, input logic [2:0] wr, input logic ws);
    bus.opcodeIn        = op;
    bus.ReadDataIn      = rd;
    bus.ImmediateDataIn = imm;
    bus.ReadRegisterIn  = rr;
    bus.WriteRegisterIn = wr;
    bus.WriteSignalIn   = ws;
  endtask

  function automatic logic model_stall();
    int n;
    n = int'(bus.ImmediateDataIn) % 8;
    if (Reset) return 1'b0;
    if (m_rem == 0) return (bus.opcodeIn == 2'b11) && (n != 0);
    return m_rem > 1;
  endfunction

  task automatic model_edge();
    int         n;
    logic [7:0] a;
    if (Reset) begin
      m_res = 8'h00; m_wreg = 3'd0; m_wen = 1'b0; m_known = 1'b1; m_rem = 0;
      return;
    end
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_res = m_pres; m_wreg = m_preg; m_wen = m_pen; m_known = 1'b1;
      end else begin
        m_wen = 1'b0;
      end
      return;
    end
    a = bus.ReadDataIn;
`ifdef EX_FORWARD_EN
    if (m_wen && m_wreg == bus.ReadRegisterIn) a = m_res;
`endif
    n = int'(bus.ImmediateDataIn) % 8;
    if (bus.opcodeIn == 2'b11 && n != 0) begin
      m_pres  = 8'((int'(a) << n) % 256);
      m_preg  = bus.WriteRegisterIn;
      m_pen   = bus.WriteSignalIn;
      m_rem   = n;
      m_wen   = 1'b0;
      m_known = 1'b0;
      return;
    end
    case (bus.opcodeIn)
      2'b00:   m_res = 8'((int'(a) + int'(bus.ImmediateDataIn)) % 256);
      2'b01:   m_res = bus.ImmediateDataIn;
      2'b10:   m_res = a ^ bus.ImmediateDataIn;
      default: m_res = a;
    endcase
    m_wreg  = bus.WriteRegisterIn;
    m_wen   = bus.WriteSignalIn;
    m_known = 1'b1;
  endtask

  // One clock: check Stall before the edge, advance the model, check outputs after.
  task automatic cycle(input logic rst);
    Reset = rst;
    #1;
    last_stall = bus.Stall;
    chk("stall", {7'd0, bus.Stall}, {7'd0, model_stall()});
    model_edge();
    @(posedge clk);
    #1;
    chk("wen", {7'd0, bus.WriteSignalOut}, {7'd0, m_wen});
    if (m_known) begin
      chk("result", bus.ResultOut, m_res);
      chk("wreg", {5'd0, bus.WriteRegisterOut}, {5'd0, m_wreg});
    end
  endtask

  initial begin
    logic [7:0] exp_fwd;
    m_rem = 0; m_known = 1'b0; m_wen = 1'b0; m_res = 8'h00; m_wreg = 3'd0;
    drive(2'b00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    cycle(1'b1);
    cycle(1'b1);
    chk("rst_result", bus.ResultOut, 8'h00);
    chk("rst_wen", {7'd0, bus.WriteSignalOut}, 8'h00);

    // ADD with carry discarded
    drive(2'b00, 8'hF0, 8'h20, 3'd7, 3'd2, 1'b1);
    cycle(1'b0);
    chk("add_result", bus.ResultOut, 8'h10);
    chk("add_wreg", {5'd0, bus.WriteRegisterOut}, 8'h02);
    chk("add_wen", {7'd0, bus.WriteSignalOut}, 8'h01);

    // Reset after nonzero outputs, with a SHL presented so Stall gating is exercised
    drive(2'b11, 8'h81, 8'h03, 3'd0, 3'd1, 1'b1);
    cycle(1'b1);
    chk("rst2_stall", {7'd0, last_stall}, 8'h00);
    chk("rst2_result", bus.ResultOut, 8'h00);
    chk("rst2_wreg", {5'd0, bus.WriteRegisterOut}, 8'h00);
    chk("rst2_wen", {7'd0, bus.WriteSignalOut}, 8'h00);

    // MOVI R3 <- 5 then ADD reading R3
    drive(2'b01, 8'h00, 8'h05, 3'd0, 3'd3, 1'b1);
    cycle(1'b0);
    drive(2'b00, 8'h00, 8'h01, 3'd3, 3'd4, 1'b1);
    cycle(1'b0);
`ifdef EX_FORWARD_EN
    exp_fwd = 8'h06;
`else
    exp_fwd = 8'h01;
`endif
    chk("fwd_add", bus.ResultOut, exp_fwd);

    // SHL 0x81 by 3, inputs held while stalled
    drive(2'b11, 8'h81, 8'h03, 3'd5, 3'd6, 1'b1);
    cycle(1'b0);
    chk("shl_stall0", {7'd0, last_stall}, 8'h01);
    chk("shl_wen0", {7'd0, bus.WriteSignalOut}, 8'h00);
    cycle(1'b0);
    chk("shl_stall1", {7'd0, last_stall}, 8'h01);
    cycle(1'b0);
    chk("shl_stall2", {7'd0, last_stall}, 8'h01);
    chk("shl_wen2", {7'd0, bus.WriteSignalOut}, 8'h00);
    cycle(1'b0);
    chk("shl_stall3", {7'd0, last_stall}, 8'h00);
    chk("shl_result", bus.ResultOut, 8'h08);
    chk("shl_wen", {7'd0, bus.WriteSignalOut}, 8'h01);
    chk("shl_wreg", {5'd0, bus.WriteRegisterOut}, 8'h06);
    drive(2'b10, 8'h00, 8'hFF, 3'd6, 3'd1, 1'b1);
    cycle(1'b0);
`ifdef EX_FORWARD_EN
    exp_fwd = 8'hF7;
`else
    exp_fwd = 8'hFF;
`endif
    chk("post_shl_xor", bus.ResultOut, exp_fwd);

    // SHL with N = 0 and Imm = 8 act as pass-through
    drive(2'b11, 8'h81, 8'h00, 3'd0, 3'd2, 1'b1);
    cycle(1'b0);
    chk("shl0_stall", {7'd0, last_stall}, 8'h00);
    chk("shl0_result", bus.ResultOut, 8'h81);
    drive(2'b11, 8'h81, 8'h08, 3'd0, 3'd2, 1'b1);
    cycle(1'b0);
    chk("shl8_stall", {7'd0, last_stall}, 8'h00);
    chk("shl8_result", bus.ResultOut, 8'h81);

    // Reset in SHIFT with count = 2 discards the SHL
    drive(2'b11, 8'h81, 8'h03, 3'd0, 3'd5, 1'b1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    chk("rsh_stall", {7'd0, last_stall}, 8'h00);
    chk("rsh_result", bus.ResultOut, 8'h00);
    chk("rsh_wen", {7'd0, bus.WriteSignalOut}, 8'h00);
    drive(2'b00, 8'h11, 8'h01, 3'd0, 3'd1, 1'b0);
    cycle(1'b0);
    chk("rsh_idle_stall", {7'd0, last_stall}, 8'h00);
    cycle(1'b0);
    chk("rsh_nowrite", {7'd0, bus.WriteSignalOut}, 8'h00);
    drive(2'b01, 8'h00, 8'h3C, 3'd0, 3'd7, 1'b1);
    cycle(1'b0);
    chk("rsh_movi", bus.ResultOut, 8'h3C);

    // Random traffic; upstream holds its inputs while Stall is high
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 3'($urandom),
              3'($urandom), 1'($urandom));
      end
      cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ex_wb.md
EX_WB -- requirements
Module: ex_wb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 opcodeIn  in  2  00 ADD, 01 MOVI, 10 XOR, 11 SHL.
REQ-005 ReadDataIn  in  8  register-file operand A from the ID/EX stage.
REQ-006 ImmediateDataIn  in  8  immediate operand; bits [2:0] are the shift amount N for SHL.
REQ-007 ReadRegisterIn  in  3  source register index of operand A.
REQ-008 WriteRegisterIn  in  3  destination register index.
REQ-009 WriteSignalIn  in  1  instruction writes its destination register.
REQ-010 ResultOut  out  8  registered ALU result for write-back.
REQ-011 WriteRegisterOut  out  3  registered destination index.
REQ-012 WriteSignalOut  out  1  registered write enable; 0 means bubble.
REQ-013 Stall  out  1  combinational; while high, upstream holds all ID/EX outputs unchanged.

Function
REQ-014 Operand A selection:
- A = ResultOut when WriteSignalOut=1 and WriteRegisterOut=ReadRegisterIn (forwarding).
- Otherwise A = ReadDataIn.
REQ-015 Single-cycle results, registered at the next edge, modulo 256:
- ADD: A+Imm, carry discarded.
- MOVI: Imm.
- XOR: A^Imm.
- SHL with N=0: A.
REQ-016 The state machine SHALL have two states, IDLE and SHIFT, and reset into IDLE.
REQ-017 IDLE, SHL with N>0: at the edge, capture A into a shift register, capture N into a count, capture WriteRegisterIn and WriteSignalIn, drive WriteSignalOut=0, and enter SHIFT.
REQ-018 SHIFT: each edge shifts the register left by 1 with zero fill and decrements count. Inputs are ignored.
REQ-019 SHIFT, edge with count=1: ResultOut = final shifted value; WriteRegisterOut and WriteSignalOut take the captured values; next state is IDLE.
REQ-020 While in SHIFT, except on the final edge, WriteSignalOut SHALL be 0.
REQ-021 Stall = (IDLE and opcodeIn=SHL and N≠0) or (SHIFT and count>1).
- Stall is high for exactly N cycles per SHL.
- Upstream advances on the same edge the SHL result is registered.
REQ-022 SHL latency SHALL be N edges after the accept edge; all other opcodes complete in 1 edge with Stall low.
REQ-023 ImmediateDataIn[7:3] SHALL be ignored for SHL, so Imm=8 behaves as N=0.
REQ-024 Back-to-back single-cycle instructions SHALL be accepted every cycle with no bubbles.

Reset
REQ-025 When Reset=1 at an edge, the block SHALL clear ResultOut, WriteRegisterOut, WriteSignalOut, the shift register and count to 0, and set the state to IDLE.
REQ-026 Stall SHALL be 0 whenever Reset=1.
REQ-027 Reset SHALL take priority over every operation; an in-flight SHL is discarded and produces no write.

Configuration
REQ-028 With EX_FORWARD_EN defined, operand A SHALL be selected as in REQ-014.
REQ-029 Without EX_FORWARD_EN, operand A SHALL always be ReadDataIn and no compare logic is built; all other behaviour is unchanged.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Reset for 1 cycle after nonzero outputs -> ResultOut=0x00, WriteRegisterOut=0, WriteSignalOut=0, Stall=0.
- ADD with ReadDataIn=0xF0, Imm=0x20, WriteRegisterIn=2, WriteSignalIn=1 -> after 1 edge: ResultOut=0x10, WriteRegisterOut=2, WriteSignalOut=1.
- MOVI R3<-0x05, then ADD with ReadRegisterIn=3, ReadDataIn=0x00, Imm=0x01 -> ResultOut=0x06 with EX_FORWARD_EN, 0x01 without.
- SHL with A=0x81, Imm=0x03, held while Stall is high -> Stall high 3 cycles; WriteSignalOut=0 after the accept edge; ResultOut=0x08 and WriteSignalOut=1 at the 3rd edge after accept; next instruction accepted on that same edge.
- SHL with A=0x81 and Imm=0x00, then Imm=0x08 -> ResultOut=0x81 after 1 edge each; Stall never high.
- Reset asserted during SHIFT with count=2 -> next edge: state IDLE, all outputs 0, Stall 0, and no write of the shifted value.
